// File: rtl/win_hist_accum.sv
// ---------------------------------------------------------------------------
// win_hist_accum
//
// Windowed per-channel accumulator for RNG sample analysis. Each enabled
// cycle in RUN adds one unsigned IN_W-bit symbol per channel into an ACC_W-bit
// accumulator and bumps a shared sample counter. After WIN_LEN enabled samples
// the accumulators freeze and are streamed out one channel per transfer over
// a valid/ready read port. done then pulses and the block returns to IDLE,
// where the last window's results stay visible until the next start.
//
// Ports:
//   clk       clock
//   rst_n     synchronous active-low reset
//   start     begin a new window (honoured only in IDLE)
//   enable    sample valid this cycle (counted only in RUN)
//   in_data   packed symbols, channel i at [i*IN_W +: IN_W]
//   busy      high in RUN and DUMP
//   total     enabled samples counted in current/last window
//   ovf       sticky per-channel overflow flags, cleared by start
//   rd_valid  readout word valid (DUMP)
//   rd_ready  consumer accepts the current word
//   rd_idx    channel index of rd_data
//   rd_data   accumulator of channel rd_idx
//   rd_last   high with rd_valid on the final channel
//   done      one-cycle pulse after the final read transfer
//
// Build option:
//   WIN_HIST_SATURATE_EN  defined   -> accumulators clamp at 2^ACC_W-1
//                         undefined -> accumulators wrap modulo 2^ACC_W
//   ovf is set on overflow in both builds.
// ---------------------------------------------------------------------------
module win_hist_accum #(
    parameter  int N_CH    = 32,
    parameter  int IN_W    = 3,
    parameter  int ACC_W   = 64,
    parameter  int WIN_LEN = 1024,
    localparam int IDX_W   = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   enable,
    input  logic [N_CH*IN_W-1:0]   in_data,
    output logic                   busy,
    output logic [ACC_W-1:0]       total,
    output logic [N_CH-1:0]        ovf,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [IDX_W-1:0]       rd_idx,
    output logic [ACC_W-1:0]       rd_data,
    output logic                   rd_last,
    output logic                   done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DUMP
    } state_t;

    localparam logic [ACC_W-1:0] WIN_LEN_C = ACC_W'(WIN_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CH - 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q [N_CH];
    logic [ACC_W-1:0]   acc_d [N_CH];
    logic [ACC_W-1:0]   total_q, total_d;
    logic [N_CH-1:0]    ovf_q, ovf_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic               done_q, done_d;

    // One extra bit per channel so the carry out of the add is the overflow.
    logic [ACC_W:0]     sum_ext [N_CH];

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            sum_ext[i] = {1'b0, acc_q[i]} + (ACC_W+1)'(in_data[i*IN_W +: IN_W]);
        end
    end

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        ovf_d    = ovf_q;
        rd_idx_d = rd_idx_q;
        done_d   = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            acc_d[i] = acc_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < N_CH; i++) begin
                        acc_d[i] = '0;
                    end
                    total_d  = '0;
                    ovf_d    = '0;
                    rd_idx_d = '0;
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                if (enable) begin
                    for (int i = 0; i < N_CH; i++) begin
`ifdef WIN_HIST_SATURATE_EN
                        acc_d[i] = sum_ext[i][ACC_W] ? {ACC_W{1'b1}} : sum_ext[i][ACC_W-1:0];
`else
                        acc_d[i] = sum_ext[i][ACC_W-1:0];
`endif
                        ovf_d[i] = ovf_q[i] | sum_ext[i][ACC_W];
                    end
                    total_d = total_q + 1'b1;
                    // The sample that completes the window is itself counted.
                    if (total_d == WIN_LEN_C) begin
                        state_d = S_DUMP;
                    end
                end
            end

            S_DUMP: begin
                if (rd_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        done_d   = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '{default: '0};
            total_q  <= '0;
            ovf_q    <= '0;
            rd_idx_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            total_q  <= total_d;
            ovf_q    <= ovf_d;
            rd_idx_q <= rd_idx_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign rd_valid = (state_q == S_DUMP);
    assign rd_last  = rd_valid && (rd_idx_q == LAST_IDX);
    assign rd_idx   = rd_idx_q;
    assign rd_data  = acc_q[rd_idx_q];
    assign total    = total_q;
    assign ovf      = ovf_q;
    assign done     = done_q;

endmodule

// File: tb/tb_win_hist_accum.sv
// ---------------------------------------------------------------------------
// tb_win_hist_accum
//
// Self-checking bench for win_hist_accum. Two instances share every input:
// one with ACC_W=8 (never overflows at WIN_LEN=4, IN_W=3) and one with
// ACC_W=4 (overflows easily), so wrap/saturate and sticky ovf behaviour are
// exercised alongside normal accumulation. The reference model keeps plain
// integer per-channel sums and derives the stored value for a given width
// from the whole-window sum (modulo or clamp), and ovf from sum > 2^W-1.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_win_hist_accum;

    localparam int N_CH    = 4;
    localparam int IN_W    = 3;
    localparam int WIN_LEN = 4;
    localparam int AW_A    = 8;
    localparam int AW_B    = 4;
    localparam int DW      = N_CH * IN_W;
    localparam int IW      = $clog2(N_CH);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              enable;
    logic [DW-1:0]     in_data;
    logic              rd_ready;

    logic              busy_a, busy_b;
    logic [AW_A-1:0]   total_a, rd_data_a;
    logic [AW_B-1:0]   total_b, rd_data_b;
    logic [N_CH-1:0]   ovf_a, ovf_b;
    logic              rd_valid_a, rd_valid_b;
    logic [IW-1:0]     rd_idx_a, rd_idx_b;
    logic              rd_last_a, rd_last_b;
    logic              done_a, done_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: true (unbounded) window sums and sample count.
    int sum [N_CH];
    int exp_total;

    logic gap_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    win_hist_accum #(
        .N_CH(N_CH), .IN_W(IN_W), .ACC_W(AW_A), .WIN_LEN(WIN_LEN)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .enable(enable),
        .in_data(in_data), .busy(busy_a), .total(total_a), .ovf(ovf_a),
        .rd_valid(rd_valid_a), .rd_ready(rd_ready), .rd_idx(rd_idx_a),
        .rd_data(rd_data_a), .rd_last(rd_last_a), .done(done_a)
    );

    win_hist_accum #(
        .N_CH(N_CH), .IN_W(IN_W), .ACC_W(AW_B), .WIN_LEN(WIN_LEN)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .enable(enable),
        .in_data(in_data), .busy(busy_b), .total(total_b), .ovf(ovf_b),
        .rd_valid(rd_valid_b), .rd_ready(rd_ready), .rd_idx(rd_idx_b),
        .rd_data(rd_data_b), .rd_last(rd_last_b), .done(done_b)
    );

    // Stored accumulator value for a window sum at accumulator width w.
    function automatic logic [63:0] exp_acc(input int s, input int w);
        int mx;
        mx = (1 << w) - 1;
`ifdef WIN_HIST_SATURATE_EN
        return 64'((s > mx) ? mx : s);
`else
        return 64'(s % (1 << w));
`endif
    endfunction

    function automatic logic [N_CH-1:0] exp_ovf(input int w);
        logic [N_CH-1:0] r;
        r = '0;
        for (int i = 0; i < N_CH; i++) begin
            r[i] = (sum[i] > (1 << w) - 1);
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N_CH; i++) begin
            sum[i] = 0;
        end
        exp_total = 0;
    endtask

    task automatic check_status(input string tag, input logic exp_busy,
                                input logic exp_valid, input logic exp_done);
        checkOutput({tag, " busy_a"},  64'(busy_a),     64'(exp_busy));
        checkOutput({tag, " busy_b"},  64'(busy_b),     64'(exp_busy));
        checkOutput({tag, " valid_a"}, 64'(rd_valid_a), 64'(exp_valid));
        checkOutput({tag, " valid_b"}, 64'(rd_valid_b), 64'(exp_valid));
        checkOutput({tag, " done_a"},  64'(done_a),     64'(exp_done));
        checkOutput({tag, " done_b"},  64'(done_b),     64'(exp_done));
        checkOutput({tag, " total_a"}, 64'(total_a),    64'(exp_total));
        checkOutput({tag, " total_b"}, 64'(total_b),    64'(exp_total));
        checkOutput({tag, " ovf_a"},   64'(ovf_a),      64'(exp_ovf(AW_A)));
        checkOutput({tag, " ovf_b"},   64'(ovf_b),      64'(exp_ovf(AW_B)));
    endtask

    // Hold reset for n cycles with start/enable active; everything clears.
    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        start    = 1'b1;
        enable   = 1'b1;
        in_data  = DW'($urandom);
        rd_ready = 1'b1;
        repeat (n) cyc();
        clear_model();
        check_status("reset", 1'b0, 1'b0, 1'b0);
        checkOutput("reset idx_a",  64'(rd_idx_a),  64'd0);
        checkOutput("reset data_a", 64'(rd_data_a), 64'd0);
        checkOutput("reset data_b", 64'(rd_data_b), 64'd0);
        rst_n    = 1'b1;
        start    = 1'b0;
        enable   = 1'b0;
        rd_ready = 1'b0;
        cyc();
        check_status("post reset", 1'b0, 1'b0, 1'b0);
    endtask

    // Start pulse from IDLE; enable during the start cycle must not count.
    task automatic do_start();
        start   = 1'b1;
        enable  = 1'b1;
        in_data = DW'($urandom);
        cyc();
        start  = 1'b0;
        enable = 1'b0;
        clear_model();
        check_status("start", 1'b1, 1'b0, 1'b0);
    endtask

    // One RUN cycle; a random start alongside it must be ignored.
    task automatic applyStimulus(input logic en, input logic [DW-1:0] d);
        enable  = en;
        in_data = d;
        start   = 1'($urandom_range(0, 1));
        if (en) begin
            for (int i = 0; i < N_CH; i++) begin
                sum[i] += int'(d[i*IN_W +: IN_W]);
            end
            exp_total++;
        end
        cyc();
        enable = 1'b0;
        start  = 1'b0;
        check_status("run", 1'b1, 1'(exp_total == WIN_LEN), 1'b0);
    endtask

    task automatic fill_window(input int gap_pct);
        for (int k = 0; k < 100 && exp_total < WIN_LEN; k++) begin
            applyStimulus(1'((k >= 40) || ($urandom_range(0, 99) >= gap_pct)), DW'($urandom));
        end
    endtask

    // Read n_words from DUMP; stall_n extra ready-low cycles at word stall_at,
    // optional random stalls elsewhere. A full read also checks done/IDLE.
    task automatic read_words(input int n_words, input int stall_at,
                              input int stall_n, input bit rand_bp);
        int stalls;
        for (int idx = 0; idx < n_words; idx++) begin
            stalls = (idx == stall_at) ? stall_n : (rand_bp ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s <= stalls; s++) begin
                rd_ready = (s == stalls);
                start    = 1'($urandom_range(0, 1));
                enable   = 1'($urandom_range(0, 1));
                in_data  = DW'($urandom);
                check_status("dump", 1'b1, 1'b1, 1'b0);
                checkOutput("dump idx_a",  64'(rd_idx_a),  64'(idx));
                checkOutput("dump idx_b",  64'(rd_idx_b),  64'(idx));
                checkOutput("dump data_a", 64'(rd_data_a), exp_acc(sum[idx], AW_A));
                checkOutput("dump data_b", 64'(rd_data_b), exp_acc(sum[idx], AW_B));
                checkOutput("dump last_a", 64'(rd_last_a), 64'(idx == N_CH - 1));
                checkOutput("dump last_b", 64'(rd_last_b), 64'(idx == N_CH - 1));
                cyc();
            end
        end
        start    = 1'b0;
        enable   = 1'b0;
        rd_ready = 1'b0;
        if (n_words == N_CH) begin
            check_status("after last", 1'b0, 1'b0, 1'b1);
            checkOutput("after last idx_a", 64'(rd_idx_a), 64'd0);
            checkOutput("after last idx_b", 64'(rd_idx_b), 64'd0);
            enable  = 1'b1;
            in_data = DW'($urandom);
            cyc();
            enable = 1'b0;
            check_status("idle hold", 1'b0, 1'b0, 1'b0);
            checkOutput("idle hold data_a", 64'(rd_data_a), exp_acc(sum[0], AW_A));
            checkOutput("idle hold data_b", 64'(rd_data_b), exp_acc(sum[0], AW_B));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b1;
        enable   = 1'b1;
        in_data  = '0;
        rd_ready = 1'b0;
        clear_model();
        @(negedge clk);

        $display("[TB] reset with start/enable held");
        do_reset(2);

        $display("[TB] basic window ch0=1 ch1=2 ch2=3 ch3=7");
        do_start();
        repeat (WIN_LEN) applyStimulus(1'b1, {3'd7, 3'd3, 3'd2, 3'd1});
        read_words(N_CH, -1, 0, 1'b0);

        $display("[TB] gapped enable, ch0=5");
        do_start();
        for (int k = 0; k < 7; k++) begin
            applyStimulus(gap_pat[k], {9'($urandom), 3'd5});
        end
        read_words(N_CH, -1, 0, 1'b1);

        $display("[TB] backpressure at idx 1");
        do_start();
        fill_window(30);
        read_words(N_CH, 1, 3, 1'b0);

        $display("[TB] overflow, ch0=7");
        do_start();
        repeat (WIN_LEN) applyStimulus(1'b1, {9'($urandom), 3'd7});
        read_words(N_CH, -1, 0, 1'b0);
        do_start();
        fill_window(20);
        read_words(N_CH, -1, 0, 1'b1);

        $display("[TB] reset mid-RUN and mid-DUMP");
        do_start();
        applyStimulus(1'b1, DW'($urandom));
        applyStimulus(1'b1, DW'($urandom));
        do_reset(1);
        do_start();
        fill_window(0);
        read_words(2, -1, 0, 1'b0);
        do_reset(1);
        do_start();
        fill_window(40);
        read_words(N_CH, -1, 0, 1'b1);

        $display("[TB] random windows");
        repeat (25) begin
            do_start();
            fill_window(int'($urandom_range(0, 60)));
            read_words(N_CH, -1, 0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/win_hist_accum.md
Name: win_hist_accum

Overview:
- Parametrised successor to the per-channel sample accumulator used in random-number analysis.
- Accumulates N_CH unsigned symbols per enabled cycle over a fixed window of WIN_LEN samples.
- Freezes the results at window end and streams the per-channel sums out over a valid/ready read port.
- Sits between the RNG sample capture stage and the result readout/host interface.

Parameters:
- N_CH, 32, number of channels (>=2).
- IN_W, 3, width of each channel input symbol.
- ACC_W, 64, width of each channel accumulator and of total.
- WIN_LEN, 1024, enabled samples per window (>=1, must fit in ACC_W).
- IDX_W, $clog2(N_CH), readout index width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- start  in  1  begin new window; honoured only in IDLE
- enable  in  1  sample valid this cycle
- in_data  in  N_CH*IN_W  packed symbols; channel i at [i*IN_W +: IN_W]
- busy  out  1  high in RUN and DUMP
- total  out  ACC_W  enabled samples counted in current/last window
- ovf  out  N_CH  sticky per-channel overflow flags
- rd_valid  out  1  readout word valid
- rd_ready  in  1  consumer accepts word
- rd_idx  out  IDX_W  channel index of rd_data
- rd_data  out  ACC_W  accumulator of channel rd_idx
- rd_last  out  1  high with rd_valid when rd_idx==N_CH-1
- done  out  1  one-cycle pulse after last read transfer

Behaviour:
- Reset (rst_n==0 at a clk edge): state IDLE; all accumulators, total, ovf, rd_idx cleared; busy, rd_valid, rd_last, done = 0. Applies from any state, including mid-RUN or mid-DUMP.
- IDLE:
  - busy=0; accumulators, total and ovf hold the last window's values; enable ignored.
  - start=1 -> next cycle: accumulators, total and ovf = 0, state RUN.
  - First sample counted is the first enable in RUN.
- RUN:
  - busy=1; start ignored.
  - Each cycle with enable=1: acc[i] <= acc[i] + zero-extended in_data[i]; total <= total+1.
  - enable=0 cycles change nothing.
  - The enabled cycle that makes total==WIN_LEN -> state DUMP next cycle; that sample is included.
- DUMP:
  - busy=1; rd_valid=1; rd_idx starts at 0; enable and start ignored.
  - rd_data = acc[rd_idx] combinationally from frozen registers.
  - Transfer on rd_valid & rd_ready; on transfer rd_idx increments.
  - rd_valid=1 with rd_ready=0: rd_idx and rd_data hold stable.
  - Transfer with rd_last=1 -> IDLE next cycle; done=1 for exactly that one cycle; rd_valid=0; rd_idx back to 0.
- Latency: rd_valid rises 1 cycle after the final enabled sample. Full readout takes N_CH transfers minimum.
- Width/overflow: an addition whose true result exceeds 2^ACC_W-1 sets ovf[i] (sticky until next start). The stored value is per the optional feature. total never overflows because WIN_LEN fits in ACC_W.

Optional Feature:
- Macro: WIN_HIST_SATURATE_EN.
- Defined: accumulators saturate at 2^ACC_W-1 on overflow; ovf[i] is still set.
- Undefined: accumulators wrap modulo 2^ACC_W; ovf[i] is set.
- All other behaviour is identical in both builds.

Test Plan:
(Parameters N_CH=4, IN_W=3, ACC_W=8, WIN_LEN=4 unless stated.)
1. Reset: rst_n=0 for 2 cycles with start=1, enable=1 -> busy=0, rd_valid=0, total=0, ovf=0, done=0.
2. Basic window: start, then 4 enabled cycles with in={ch0=1, ch1=2, ch2=3, ch3=7}, rd_ready=1 -> rd_valid one cycle after the 4th sample. Reads idx 0..3 = 4, 8, 12, 28; rd_last on idx 3; total=4; done pulses the cycle after that transfer.
3. Gapped enable: enable pattern 1,0,0,1,1,0,1 with ch0=5 -> RUN ends after the 7th cycle; acc0=20; total=4; zero-valued cycles not counted.
4. Backpressure: in DUMP hold rd_ready=0 for 3 cycles at idx 1 -> rd_idx=1 and rd_data stable; resume -> remaining words in order, no loss or duplication.
5. Overflow, ACC_W=4: ch0=7 for 4 samples -> without macro rd_data[0]=12 (28 mod 16) and ovf[0]=1; with WIN_HIST_SATURATE_EN rd_data[0]=15 and ovf[0]=1; ovf[0] clears on next start.
6. Reset mid-operation: rst_n=0 after 2 samples in RUN, and again at idx 2 in DUMP -> IDLE, all cleared, no done pulse. A following start runs a correct fresh window. start asserted during RUN/DUMP has no effect.
